// File: rtl/pio_gen2.sv
`default_nettype none
// ============================================================================
// Module      : pio_gen2
// Description : Parametrised general-purpose I/O block on an Avalon-MM slave.
//               Provides a per-bit direction register, atomic set/clear of the
//               output data, synchronised input sampling, sticky per-bit edge
//               capture and a maskable, registered level interrupt.
// Ports       : clk, reset (async, active-high)
//               address/chipselect/write_n/writedata/readdata - Avalon-MM slave
//               in_port  - asynchronous pin inputs
//               out_port - registered output data
//               out_en   - per-bit output enable (direction register)
//               irq      - level interrupt
// Revision    : 1.0 - initial release
// ============================================================================
module pio_gen2 #(
    parameter int          WIDTH       = 10,
    parameter logic [31:0] RESET_VALUE = 32'h0,
    parameter logic [31:0] DIR_RESET   = 32'h0,
    parameter int          EDGE_TYPE   = 0,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] out_en,
    output logic             irq
);

    localparam logic [2:0] c_ADDR_DATA   = 3'd0;
    localparam logic [2:0] c_ADDR_DIR    = 3'd1;
    localparam logic [2:0] c_ADDR_IRQMSK = 3'd2;
    localparam logic [2:0] c_ADDR_EDGE   = 3'd3;
    localparam logic [2:0] c_ADDR_OUTSET = 3'd4;
    localparam logic [2:0] c_ADDR_OUTCLR = 3'd5;

    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [WIDTH-1:0] direction_q, direction_d;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] in_prev_q;
    logic             irq_q, irq_d;

    logic             w_wr;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_in_sync;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;

    assign w_wr      = chipselect & ~write_n;
    assign w_wdata   = writedata[WIDTH-1:0];
    assign w_in_sync = sync_q[SYNC_STAGES-1];

    // Upper write-data bits have no destination when the block is narrower
    // than the bus.
    generate
        if (WIDTH < 32) begin : g_wd_unused
            logic w_unused_wd;
            assign w_unused_wd = ^writedata[31:WIDTH];
        end
    endgenerate

    // Edge detector works on the synchronised sample against its previous
    // value, independent of pin direction.
    generate
        if (EDGE_TYPE == 0) begin : g_edge_rise
            assign w_edge = w_in_sync & ~in_prev_q;
        end else if (EDGE_TYPE == 1) begin : g_edge_fall
            assign w_edge = ~w_in_sync & in_prev_q;
        end else begin : g_edge_any
            assign w_edge = w_in_sync ^ in_prev_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state logic for the register file
    // ------------------------------------------------------------------
    always_comb begin
        data_out_d  = data_out_q;
        direction_d = direction_q;
        irqmask_d   = irqmask_q;
        w_clr       = '0;
        if (w_wr) begin
            case (address)
                c_ADDR_DATA:   data_out_d  = w_wdata;
                c_ADDR_DIR:    direction_d = w_wdata;
                c_ADDR_IRQMSK: irqmask_d   = w_wdata;
                c_ADDR_EDGE:   w_clr       = w_wdata;
                c_ADDR_OUTSET: data_out_d  = data_out_q | w_wdata;
                c_ADDR_OUTCLR: data_out_d  = data_out_q & ~w_wdata;
                default:       ;
            endcase
        end
        // A fresh edge is OR-ed in after the clear so set wins on a collision.
        edgecap_d = (edgecap_q & ~w_clr) | w_edge;
        irq_d     = |(edgecap_q & irqmask_q);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out_q  <= RESET_VALUE[WIDTH-1:0];
            direction_q <= DIR_RESET[WIDTH-1:0];
            irqmask_q   <= '0;
            edgecap_q   <= '0;
            in_prev_q   <= '0;
            irq_q       <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            data_out_q  <= data_out_d;
            direction_q <= direction_d;
            irqmask_q   <= irqmask_d;
            edgecap_q   <= edgecap_d;
            in_prev_q   <= w_in_sync;
            irq_q       <= irq_d;
            sync_q[0]   <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Zero-latency read mux; unused upper bits and write-only/reserved
    // addresses read as zero.
    // ------------------------------------------------------------------
    always_comb begin
        readdata = '0;
        case (address)
            c_ADDR_DATA:   readdata[WIDTH-1:0] = (direction_q & data_out_q) |
                                                 (~direction_q & w_in_sync);
            c_ADDR_DIR:    readdata[WIDTH-1:0] = direction_q;
            c_ADDR_IRQMSK: readdata[WIDTH-1:0] = irqmask_q;
            c_ADDR_EDGE:   readdata[WIDTH-1:0] = edgecap_q;
            default:       readdata = '0;
        endcase
    end

    assign out_port = data_out_q;
    assign out_en   = direction_q;
    assign irq      = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_pio_gen2.sv
`default_nettype none
// ============================================================================
// Module      : tb_pio_gen2
// Description : Scoreboard bench for pio_gen2. Instance A uses the default
//               10-bit rising-edge configuration; instance B is 4 bits wide
//               with any-edge capture. Stimulus pushes expected values into a
//               queue; a negedge monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pio_gen2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic [2:0]  a_addr = '0;
    logic        a_cs = 1'b0;
    logic        a_wn = 1'b1;
    logic [31:0] a_wdata = '0;
    logic [31:0] a_rdata;
    logic [9:0]  a_in = '0;
    logic [9:0]  a_out;
    logic [9:0]  a_oen;
    logic        a_irq;

    logic [2:0]  b_addr = '0;
    logic        b_cs = 1'b0;
    logic        b_wn = 1'b1;
    logic [31:0] b_wdata = '0;
    logic [31:0] b_rdata;
    logic [3:0]  b_in = '0;
    logic [3:0]  b_out;
    logic [3:0]  b_oen;
    logic        b_irq;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } chk_t;
    chk_t sb[$];

    localparam int K_RD_A = 0, K_OUT_A = 1, K_OEN_A = 2, K_IRQ_A = 3;
    localparam int K_RD_B = 4, K_IRQ_B = 5, K_OEN_B = 6, K_OUT_B = 7;

    pio_gen2 u_dut_a (
        .clk        (clk),
        .reset      (reset),
        .address    (a_addr),
        .chipselect (a_cs),
        .write_n    (a_wn),
        .writedata  (a_wdata),
        .readdata   (a_rdata),
        .in_port    (a_in),
        .out_port   (a_out),
        .out_en     (a_oen),
        .irq        (a_irq)
    );

    pio_gen2 #(.WIDTH(4), .EDGE_TYPE(2), .SYNC_STAGES(2)) u_dut_b (
        .clk        (clk),
        .reset      (reset),
        .address    (b_addr),
        .chipselect (b_cs),
        .write_n    (b_wn),
        .writedata  (b_wdata),
        .readdata   (b_rdata),
        .in_port    (b_in),
        .out_port   (b_out),
        .out_en     (b_oen),
        .irq        (b_irq)
    );

    always #5 clk = ~clk;

    // Monitor: drains every expectation queued during the current cycle.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            chk_t        e;
            logic [31:0] act;
            e = sb.pop_front();
            case (e.kind)
                K_RD_A:  act = a_rdata;
                K_OUT_A: act = 32'(a_out);
                K_OEN_A: act = 32'(a_oen);
                K_IRQ_A: act = 32'(a_irq);
                K_RD_B:  act = b_rdata;
                K_IRQ_B: act = 32'(b_irq);
                K_OEN_B: act = 32'(b_oen);
                default: act = 32'(b_out);
            endcase
            checks++;
            if (act !== e.exp) begin
                failures++;
                $display("FAIL %s: actual=0x%08h expected=0x%08h", e.name, act, e.exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input int kind, input logic [31:0] exp, input string name);
        chk_t e;
        e.kind = kind;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic wr(input bit b, input logic [2:0] a, input logic [31:0] d);
        if (!b) begin
            a_addr = a; a_wdata = d; a_cs = 1'b1; a_wn = 1'b0;
        end else begin
            b_addr = a; b_wdata = d; b_cs = 1'b1; b_wn = 1'b0;
        end
        step();
        a_cs = 1'b0; a_wn = 1'b1;
        b_cs = 1'b0; b_wn = 1'b1;
    endtask

    // Presents a read this cycle; the caller's next step() lets it be sampled.
    task automatic rd(input bit b, input logic [2:0] a, input logic [31:0] exp,
                      input string name);
        if (!b) begin
            a_addr = a; a_cs = 1'b1; a_wn = 1'b1;
            expect_v(K_RD_A, exp, name);
        end else begin
            b_addr = a; b_cs = 1'b1; b_wn = 1'b1;
            expect_v(K_RD_B, exp, name);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        repeat (3) step();
        reset = 1'b0;
        step();

        // ---- reset asserted asynchronously during a DATA write ----
        a_addr = 3'd0; a_wdata = 32'h3FF; a_cs = 1'b1; a_wn = 1'b0;
        step();
        expect_v(K_OUT_A, 32'h3FF, "pre_reset_out");
        #5 reset = 1'b1;
        #2 begin a_cs = 1'b0; a_wn = 1'b1; end
        #1 reset = 1'b0;
        step();
        expect_v(K_OUT_A, 32'h000, "rst_out_port");
        expect_v(K_OEN_A, 32'h000, "rst_out_en");
        expect_v(K_IRQ_A, 32'h0,   "rst_irq");
        expect_v(K_OUT_B, 32'h0,   "rst_b_out_port");
        step();
        for (int i = 0; i < 8; i++) begin
            rd(0, 3'(i), 32'h0, $sformatf("rst_read_addr%0d", i));
            step();
        end

        // ---- set / clear ----
        a_addr = 3'd0; a_wdata = 32'h0F0; a_cs = 1'b1; a_wn = 1'b0;
        expect_v(K_OUT_A, 32'h000, "data_before_edge");
        step(); a_cs = 1'b0; a_wn = 1'b1;
        expect_v(K_OUT_A, 32'h0F0, "data_write");
        wr(0, 3'd4, 32'h00F);
        expect_v(K_OUT_A, 32'h0FF, "outset");
        wr(0, 3'd5, 32'h0C0);
        expect_v(K_OUT_A, 32'h03F, "outclear");

        // ---- ignored writes: reserved address, chipselect low ----
        wr(0, 3'd6, 32'hFFF);
        expect_v(K_OUT_A, 32'h03F, "reserved_write");
        a_addr = 3'd0; a_wdata = 32'h3FF; a_cs = 1'b0; a_wn = 1'b0;
        step(); a_wn = 1'b1;
        expect_v(K_OUT_A, 32'h03F, "cs_low_write");
        rd(0, 3'd6, 32'h0, "reserved_read");
        step();

        // ---- direction readback ----
        wr(0, 3'd1, 32'h00F);
        wr(0, 3'd0, 32'h3FF);
        a_in = 10'h2A0;
        repeat (3) step();
        rd(0, 3'd0, 32'h2AF, "dir_data_read");
        expect_v(K_OEN_A, 32'h00F, "dir_out_en");
        step();
        rd(0, 3'd1, 32'h00F, "dir_read");
        step();
        a_in = 10'h000;
        repeat (4) step();
        wr(0, 3'd3, 32'h3FF);
        rd(0, 3'd3, 32'h0, "ecap_cleared");
        step();

        // ---- rising edge on bit 0 with mask, cycle-exact ----
        wr(0, 3'd2, 32'h001);
        a_in = 10'h001;
        rd(0, 3'd3, 32'h0, "ecap_c0"); step();
        step();
        rd(0, 3'd3, 32'h0, "ecap_c2"); expect_v(K_IRQ_A, 32'h0, "irq_c2"); step();
        rd(0, 3'd3, 32'h1, "ecap_c3"); expect_v(K_IRQ_A, 32'h0, "irq_c3"); step();
        expect_v(K_IRQ_A, 32'h1, "irq_c4");
        wr(0, 3'd3, 32'h001);
        expect_v(K_IRQ_A, 32'h1, "irq_at_clear_edge");
        step();
        expect_v(K_IRQ_A, 32'h0, "irq_after_clear");
        rd(0, 3'd3, 32'h0, "ecap_after_clear");
        step();

        // ---- simultaneous detect and clear on bit 1 ----
        a_in = 10'h003;
        repeat (3) step();
        rd(0, 3'd3, 32'h2, "ecap_bit1"); expect_v(K_IRQ_A, 32'h0, "irq_masked_bit1");
        step();
        a_in = 10'h001;
        repeat (3) step();
        a_in = 10'h003;
        step(); step();
        wr(0, 3'd3, 32'h002);
        rd(0, 3'd3, 32'h2, "ecap_set_wins"); expect_v(K_IRQ_A, 32'h0, "irq_still_masked");
        step();
        wr(0, 3'd3, 32'h001);
        rd(0, 3'd3, 32'h2, "clear_no_pending");
        step();
        wr(0, 3'd2, 32'h002);
        expect_v(K_IRQ_A, 32'h0, "irq_mask_edge");
        step();
        expect_v(K_IRQ_A, 32'h1, "irq_after_mask");
        step();

        // ---- instance B: 4-bit, any-edge ----
        wr(1, 3'd1, 32'hFFFF_FFFF);
        rd(1, 3'd1, 32'h0000_000F, "b_dir_read");
        expect_v(K_OEN_B, 32'hF, "b_out_en");
        step();
        wr(1, 3'd1, 32'h0);
        b_in = 4'h8;
        repeat (3) step();
        rd(1, 3'd0, 32'h8, "b_data_read"); step();
        rd(1, 3'd3, 32'h8, "b_ecap_rise"); expect_v(K_IRQ_B, 32'h0, "b_irq_unmasked");
        step();
        wr(1, 3'd3, 32'h8);
        rd(1, 3'd3, 32'h0, "b_ecap_clear1"); step();
        b_in = 4'h0;
        repeat (3) step();
        rd(1, 3'd3, 32'h8, "b_ecap_fall"); step();
        wr(1, 3'd3, 32'h8);
        rd(1, 3'd3, 32'h0, "b_ecap_clear2"); step();

        step();
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: actual=%0d pending expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
